// File: rtl/seg7_decoder_monitor.sv
// seg7_decoder_monitor
// Receive-side monitor for a 7-segment display bus. It does four things:
//   - deglitches seg_in,
//   - decodes each accepted pattern back to a BCD digit,
//   - flags accepted patterns that are not a canonical digit,
//   - optionally checks the digit sequence (count direction, step count,
//     skipped digits).
//
// Configuration macro: SEG7_SEQ_CHECK_EN
//   defined   : the sequence checker is built.
//   undefined : dir_up, dir_known, seq_err and step_count are tied to 0.
//
// Deglitch rule:
//   - A pattern is accepted on the edge where it has been sampled for the
//     STABLE_CYCLES-th consecutive time.
//   - It is accepted only if nothing has been accepted since reset, or if it
//     differs from the last accepted pattern.
//   - The run counter saturates, so a pattern that stays on the bus never
//     fires again.

module seg7_decoder_monitor #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [3:0] digit,
    output logic       digit_stb,
    output logic       pattern_err,
    output logic       dir_up,
    output logic       dir_known,
    output logic [7:0] step_count,
    output logic       seq_err
);

    localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);

    // Deglitch state
    logic [6:0] cand;
    logic [3:0] cnt;
    logic [6:0] last_pat;
    logic       have_pat;

    // Combinational results for the current edge
    logic       cand_match;
    logic [3:0] cnt_next;
    logic       accept;
    logic       dec_valid;
    logic [3:0] dec_digit;
    logic       acc_valid;

    // Map a g..a pattern to {valid, digit}; anything non-canonical is invalid.
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        logic [4:0] r;
        r = 5'b0_0000;
        case (pat)
            7'h3F: r = 5'b1_0000;
            7'h06: r = 5'b1_0001;
            7'h5B: r = 5'b1_0010;
            7'h4F: r = 5'b1_0011;
            7'h66: r = 5'b1_0100;
            7'h6D: r = 5'b1_0101;
            7'h7D: r = 5'b1_0110;
            7'h07: r = 5'b1_0111;
            7'h7F: r = 5'b1_1000;
            7'h6F: r = 5'b1_1001;
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    // Next run length, acceptance decision and decode of the sampled pattern.
    // The candidate after this edge is always seg_in, so the accepted pattern
    // is seg_in itself.
    always_comb begin
        cand_match = (seg_in == cand);
        cnt_next   = 4'd1;
        if (cand_match) begin
            cnt_next = (cnt == STABLE_MAX) ? cnt : 4'(cnt + 4'd1);
        end
        accept = (cnt_next == STABLE_MAX)
               && !(cand_match && (cnt == STABLE_MAX))
               && (!have_pat || (seg_in != last_pat));
        {dec_valid, dec_digit} = decode_seg(seg_in);
        acc_valid = accept && dec_valid;
    end

    // Candidate tracking and memory of the last accepted pattern.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand     <= 7'h00;
            cnt      <= 4'd0;
            last_pat <= 7'h00;
            have_pat <= 1'b0;
        end else begin
            cand <= seg_in;
            cnt  <= cnt_next;
            if (accept) begin
                last_pat <= seg_in;
                have_pat <= 1'b1;
            end
        end
    end

    // Decoded digit plus one-cycle strobe / error pulses on acceptance.
    // An invalid pattern leaves digit unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit       <= 4'd0;
            digit_stb   <= 1'b0;
            pattern_err <= 1'b0;
        end else begin
            digit_stb   <= acc_valid;
            pattern_err <= accept && !dec_valid;
            if (acc_valid) begin
                digit <= dec_digit;
            end
        end
    end

`ifdef SEG7_SEQ_CHECK_EN
    logic [3:0] prev_digit;
    logic       have_prev;
    logic [3:0] up_digit;
    logic [3:0] dn_digit;

    // Neighbours of the previous digit, with 9<->0 wrap.
    always_comb begin
        up_digit = (prev_digit == 4'd9) ? 4'd0 : 4'(prev_digit + 4'd1);
        dn_digit = (prev_digit == 4'd0) ? 4'd9 : 4'(prev_digit - 4'd1);
    end

    // Classify each new valid digit against the previous one.
    // The first digit after reset only seeds prev_digit.
    // A repeated digit is neither a step nor an error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_digit <= 4'd0;
            have_prev  <= 1'b0;
            dir_up     <= 1'b0;
            dir_known  <= 1'b0;
            step_count <= 8'd0;
            seq_err    <= 1'b0;
        end else begin
            seq_err <= 1'b0;
            if (acc_valid) begin
                prev_digit <= dec_digit;
                have_prev  <= 1'b1;
                if (have_prev) begin
                    if (dec_digit == up_digit) begin
                        dir_up     <= 1'b1;
                        dir_known  <= 1'b1;
                        step_count <= step_count + 8'd1;
                    end else if (dec_digit == dn_digit) begin
                        dir_up     <= 1'b0;
                        dir_known  <= 1'b1;
                        step_count <= step_count + 8'd1;
                    end else if (dec_digit != prev_digit) begin
                        seq_err <= 1'b1;
                    end
                end
            end
        end
    end
`else
    assign dir_up     = 1'b0;
    assign dir_known  = 1'b0;
    assign step_count = 8'd0;
    assign seq_err    = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_decoder_monitor.sv
// tb_seg7_decoder_monitor
// Directed-vector bench for seg7_decoder_monitor with STABLE_CYCLES = 4.
// Expected values for the sequence-checker outputs are 0 unless
// SEG7_SEQ_CHECK_EN is defined.

module tb_seg7_decoder_monitor;

`ifdef SEG7_SEQ_CHECK_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_in;
    logic [3:0] digit;
    logic       digit_stb;
    logic       pattern_err;
    logic       dir_up;
    logic       dir_known;
    logic [7:0] step_count;
    logic       seq_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse counters and scoreboard, updated by the monitor
    int stb_cnt  = 0;
    int perr_cnt = 0;
    int serr_cnt = 0;
    logic prev_stb  = 1'b0;
    logic prev_perr = 1'b0;
    logic [3:0] exp_q[$];

    // Canonical segment patterns for digits 0..9
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    seg7_decoder_monitor #(.STABLE_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .digit      (digit),
        .digit_stb  (digit_stb),
        .pattern_err(pattern_err),
        .dir_up     (dir_up),
        .dir_known  (dir_known),
        .step_count (step_count),
        .seq_err    (seq_err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (digit_stb === 1'b1) begin
                stb_cnt++;
                if (prev_stb === 1'b1) check("stb_width", 2, 1);
                if (exp_q.size() == 0) check("stb_unexpected", 1, 0);
                else check("stb_digit", digit, exp_q.pop_front());
            end
            if (pattern_err === 1'b1) begin
                perr_cnt++;
                if (prev_perr === 1'b1) check("perr_width", 2, 1);
            end
            if (seq_err === 1'b1) serr_cnt++;
        end
        prev_stb  = digit_stb;
        prev_perr = pattern_err;
    end

    // ---------------- driver tasks ----------------
    // Present pat for exactly n rising edges, then return after the
    // following falling edge (monitor already sampled).
    task automatic hold(input logic [6:0] pat, input int n);
        seg_in = pat;
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // One reset edge; seg_in is left untouched.
    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_digit"}, digit, 0);
        check({tag, "_stb"}, digit_stb, 0);
        check({tag, "_perr"}, pattern_err, 0);
        check({tag, "_dir_up"}, dir_up, 0);
        check({tag, "_dir_known"}, dir_known, 0);
        check({tag, "_steps"}, step_count, 0);
        check({tag, "_seq_err"}, seq_err, 0);
    endtask

    task automatic expect_seq(input string tag, input int d, input int up,
                              input int known, input int steps);
        check({tag, "_digit"}, digit, d);
        check({tag, "_dir_up"}, dir_up, SEQ ? up : 0);
        check({tag, "_dir_known"}, dir_known, SEQ ? known : 0);
        check({tag, "_steps"}, step_count, SEQ ? steps : 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int b_stb, b_perr, b_serr;
        rst_n  = 1'b0;
        seg_in = 7'h00;

        // T1: reset state, then latency of the first acceptance
        do_reset();
        check_all_zero("reset");
        b_stb = stb_cnt; b_serr = serr_cnt;
        hold(7'h06, 3);
        check("t1_no_stb_early", stb_cnt - b_stb, 0);
        exp_q.push_back(4'd1);
        hold(7'h06, 1);
        check("t1_stb_count", stb_cnt - b_stb, 1);
        check("t1_seq_err", serr_cnt - b_serr, 0);
        expect_seq("t1", 1, 0, 0, 0);
        hold(7'h06, 6);
        check("t1_no_refire", stb_cnt - b_stb, 1);

        // T2: full up count 0..9,0
        do_reset();
        b_stb = stb_cnt; b_serr = serr_cnt;
        for (int i = 0; i <= 10; i++) begin
            exp_q.push_back(4'(i % 10));
            hold(seg_tab[i % 10], 4);
        end
        check("t2_stb_count", stb_cnt - b_stb, 11);
        check("t2_seq_err", serr_cnt - b_serr, 0);
        expect_seq("t2", 0, 1, 1, 10);

        // T3: down count with wrap 0 -> 9 -> 8
        do_reset();
        b_serr = serr_cnt;
        exp_q.push_back(4'd0); hold(7'h3F, 4);
        exp_q.push_back(4'd9); hold(7'h6F, 4);
        exp_q.push_back(4'd8); hold(7'h7F, 4);
        check("t3_seq_err", serr_cnt - b_serr, 0);
        expect_seq("t3", 8, 0, 1, 2);

        // T4: skipped digit 1 -> 4, then 4 -> 5 is an up step
        do_reset();
        b_serr = serr_cnt;
        exp_q.push_back(4'd1); hold(7'h06, 4);
        exp_q.push_back(4'd4); hold(7'h66, 4);
        check("t4_seq_err", serr_cnt - b_serr, SEQ ? 1 : 0);
        expect_seq("t4_skip", 4, 0, 0, 0);
        exp_q.push_back(4'd5); hold(7'h6D, 4);
        check("t4_seq_err_after", serr_cnt - b_serr, SEQ ? 1 : 0);
        expect_seq("t4_step", 5, 1, 1, 1);

        // T5: glitch, invalid patterns, re-accept of the same digit
        do_reset();
        b_stb = stb_cnt; b_perr = perr_cnt; b_serr = serr_cnt;
        exp_q.push_back(4'd1); hold(7'h06, 4);
        hold(7'h07, 2);
        hold(7'h06, 4);
        check("t5_glitch_stb", stb_cnt - b_stb, 1);
        check("t5_glitch_perr", perr_cnt - b_perr, 0);
        hold(7'h7C, 4);
        check("t5_perr_7c", perr_cnt - b_perr, 1);
        check("t5_digit_hold", digit, 1);
        hold(7'h67, 4);
        check("t5_perr_67", perr_cnt - b_perr, 2);
        exp_q.push_back(4'd1); hold(7'h06, 4);
        check("t5_reaccept_stb", stb_cnt - b_stb, 2);
        check("t5_seq_err", serr_cnt - b_serr, 0);
        expect_seq("t5", 1, 0, 0, 0);

        // T6: reset mid-deglitch discards the partial pattern and the previous digit
        do_reset();
        exp_q.push_back(4'd1); hold(7'h06, 4);
        hold(7'h5B, 2);
        do_reset();
        check_all_zero("t6_reset");
        b_stb = stb_cnt; b_serr = serr_cnt;
        hold(7'h5B, 2);
        check("t6_restart", stb_cnt - b_stb, 0);
        exp_q.push_back(4'd2); hold(7'h5B, 2);
        check("t6_stb", stb_cnt - b_stb, 1);
        check("t6_seq_err", serr_cnt - b_serr, 0);
        expect_seq("t6", 2, 0, 0, 0);

        // T7: all-off pattern right after reset is accepted as invalid
        do_reset();
        b_stb = stb_cnt; b_perr = perr_cnt;
        hold(7'h00, 4);
        check("t7_perr", perr_cnt - b_perr, 1);
        check("t7_stb", stb_cnt - b_stb, 0);
        check("t7_digit", digit, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
